// File: rtl/edge_detect_pkg.sv
// Shared definitions for the edge detector bank.
// Holds the per-channel edge-mode encoding and a helper that decides
// whether a level change in a given direction is reported for a mode.
package edge_detect_pkg;

    // Per-channel edge select, two bits per channel on the mode bus
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned MODE_W = 2;

    // True when a level change towards new_level is reported under mode
    function automatic logic edge_qualifies(input logic [MODE_W-1:0] mode,
                                            input logic              new_level);
        logic w_hit;
        if (new_level) begin
            w_hit = (mode == MODE_RISE) || (mode == MODE_BOTH);
        end else begin
            w_hit = (mode == MODE_FALL) || (mode == MODE_BOTH);
        end
        return w_hit;
    endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// One channel of the edge detector bank.
// Synchronizes a raw asynchronous input, debounces it into a stable level,
// and reports qualified level changes as a one-cycle pulse plus sticky
// pending / overrun flags.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   i_sig          : raw asynchronous input
//   i_mode         : edge select (off / rise / fall / both)
//   i_clr          : clears pending and overrun
//   o_level        : debounced level
//   o_edge_pulse   : single-cycle qualified edge event
//   o_pending      : sticky event flag
//   o_overrun      : sticky lost-event flag
module edge_detect_channel
    import edge_detect_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_sig,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_clr,
    output logic              o_level,
    output logic              o_edge_pulse,
    output logic              o_pending,
    output logic              o_overrun
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_pending;
    logic                   r_overrun;

    logic w_sampled;
    logic w_differs;
    logic w_accept;
    logic w_qual;

    // Last synchronizer stage is the value the debouncer sees
    assign w_sampled = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_sampled != r_level);
    // Level is updated on the edge where the disagreement run completes
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);
    assign w_qual    = w_accept && edge_qualifies(i_mode, w_sampled);

    // Synchronizer chain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
        end
    end

    // Debounce counter and accepted level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (!w_differs) begin
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= w_sampled;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Event pulse and sticky flags; a new event beats a clear for pending,
    // while a clear always wins for overrun
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pulse   <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pulse <= w_qual;
            if (w_qual) begin
                r_pending <= 1'b1;
            end else if (i_clr) begin
                r_pending <= 1'b0;
            end
            if (i_clr) begin
                r_overrun <= 1'b0;
            end else if (w_qual && r_pending) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_level      = r_level;
    assign o_edge_pulse = r_pulse;
    assign o_pending    = r_pending;
    assign o_overrun    = r_overrun;

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of independent synchronized, debounced edge detectors.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   sig_in       : raw asynchronous inputs, one per channel
//   mode         : per-channel edge select at bits [2i+1:2i]
//   clr          : per-channel clear of pending and overrun
//   level        : debounced levels
//   edge_pulse   : single-cycle qualified edge events
//   pending      : sticky event flags
//   overrun      : sticky lost-event flags
//   any_pending  : OR of all pending flags (combinational)
module edge_detect_bank
    import edge_detect_pkg::*;
#(
    parameter int unsigned CHANNELS        = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        sig_in,
    input  logic [MODE_W*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]        clr,
    output logic [CHANNELS-1:0]        level,
    output logic [CHANNELS-1:0]        edge_pulse,
    output logic [CHANNELS-1:0]        pending,
    output logic [CHANNELS-1:0]        overrun,
    output logic                       any_pending
);

    // One self-contained detector per channel
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        edge_detect_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .i_sig        (sig_in[g]),
            .i_mode       (mode[MODE_W*g +: MODE_W]),
            .i_clr        (clr[g]),
            .o_level      (level[g]),
            .o_edge_pulse (edge_pulse[g]),
            .o_pending    (pending[g]),
            .o_overrun    (overrun[g])
        );
    end

    assign any_pending = |pending;

endmodule

// File: tb/tb_edge_detect_bank.sv
module tb_edge_detect_bank;

    localparam int unsigned CH = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [CH-1:0]   sig_in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   level;
    logic [CH-1:0]   edge_pulse;
    logic [CH-1:0]   pending;
    logic [CH-1:0]   overrun;
    logic            any_pending;

    int total = 0;
    int bad   = 0;

    edge_detect_bank #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sig_in      (sig_in),
        .mode        (mode),
        .clr         (clr),
        .level       (level),
        .edge_pulse  (edge_pulse),
        .pending     (pending),
        .overrun     (overrun),
        .any_pending (any_pending)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sig_in history delayed by the synchronizer depth,
    // plus a per-channel run length of disagreement with the held level.
    logic [CH-1:0] m_level, m_pulse, m_pend, m_ovr;
    int            m_run [CH];
    logic [CH-1:0] hist [$];

    task automatic model_reset();
        m_level = '0;
        m_pulse = '0;
        m_pend  = '0;
        m_ovr   = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back('0);
    endtask

    task automatic model_step();
        logic [CH-1:0] seen;
        logic          evt, want;
        seen = hist.pop_front();
        hist.push_back(sig_in);
        for (int i = 0; i < CH; i++) begin
            evt = 1'b0;
            if (seen[i] != m_level[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_level[i] = seen[i];
                    m_run[i]   = 0;
                    evt        = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
            // bit 0 of a channel's mode enables rises, bit 1 enables falls
            want = evt && (m_level[i] ? mode[2*i] : mode[2*i+1]);
            m_pulse[i] = want;
            if (want && m_pend[i] && !clr[i]) m_ovr[i] = 1'b1;
            if (clr[i]) begin
                m_ovr[i] = 1'b0;
                if (!want) m_pend[i] = 1'b0;
            end
            if (want) m_pend[i] = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_eq("level",       32'(level),       32'(m_level));
        check_eq("edge_pulse",  32'(edge_pulse),  32'(m_pulse));
        check_eq("pending",     32'(pending),     32'(m_pend));
        check_eq("overrun",     32'(overrun),     32'(m_ovr));
        check_eq("any_pending", 32'(any_pending), 32'(|m_pend));
    endtask

    // One clock: advance the model on the edge, compare, return at negedge
    task automatic cycle();
        @(posedge clock);
        if (reset) model_reset();
        else       model_step();
        #1;
        compare_all();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = '0;
        mode   = '0;
        clr    = '0;
        model_reset();
        #2;
        check_eq("rst_level",   32'(level),       32'h0);
        check_eq("rst_pending", 32'(pending),     32'h0);
        check_eq("rst_any",     32'(any_pending), 32'h0);
        @(negedge clock);
        do_reset();

        // ch0 rise: pulse only after the (SS+DB)th edge
        mode[1:0] = 2'b01;
        sig_in[0] = 1'b1;
        for (int k = 1; k <= int'(SS + DB); k++) begin
            cycle();
            check_eq("lat_pulse0", 32'(edge_pulse[0]), (k == int'(SS + DB)) ? 32'h1 : 32'h0);
        end
        check_eq("lat_pend0", 32'(pending[0]),  32'h1);
        check_eq("lat_any",   32'(any_pending), 32'h1);
        cycle();
        check_eq("lat_pulse0_off", 32'(edge_pulse[0]), 32'h0);

        // ch1 three-cycle glitch is filtered
        mode[3:2] = 2'b01;
        sig_in[1] = 1'b1;
        repeat (DB - 1) cycle();
        sig_in[1] = 1'b0;
        repeat (10) cycle();
        check_eq("glitch_level1", 32'(level[1]),   32'h0);
        check_eq("glitch_pend1",  32'(pending[1]), 32'h0);

        // ch2 both edges twice without clearing, then clear
        mode[5:4] = 2'b11;
        sig_in[2] = 1'b1;
        repeat (SS + DB + 2) cycle();
        sig_in[2] = 1'b0;
        repeat (SS + DB + 2) cycle();
        check_eq("ovr2_set",  32'(overrun[2]), 32'h1);
        clr[2] = 1'b1;
        cycle();
        clr[2] = 1'b0;
        check_eq("ovr2_clr",  32'(overrun[2]), 32'h0);
        check_eq("pend2_clr", 32'(pending[2]), 32'h0);

        // ch3 fall with clear arriving on the event edge
        mode[7:6] = 2'b10;
        sig_in[3] = 1'b1;
        repeat (SS + DB + 2) cycle();
        sig_in[3] = 1'b0;
        repeat (SS + DB - 1) cycle();
        clr[3] = 1'b1;
        cycle();
        clr[3] = 1'b0;
        check_eq("setwins_pend3", 32'(pending[3]), 32'h1);
        check_eq("setwins_ovr3",  32'(overrun[3]), 32'h0);

        // ch4 mode off still tracks level
        mode[9:8] = 2'b00;
        sig_in[4] = 1'b1;
        repeat (SS + DB + 1) cycle();
        check_eq("off_level4", 32'(level[4]),   32'h1);
        check_eq("off_pend4",  32'(pending[4]), 32'h0);

        // all-high inputs through reset, then reset mid-debounce
        sig_in = '1;
        mode   = {CH{2'b01}};
        do_reset();
        repeat (SS + DB - 1) cycle();
        check_eq("rel_nopulse", 32'(edge_pulse), 32'h0);
        cycle();
        check_eq("rel_pulse",   32'(edge_pulse), 32'(CH'('1)));
        sig_in = '0;
        repeat (SS + 2) cycle();
        do_reset();
        repeat (12) cycle();
        check_eq("mid_rst_pend", 32'(pending), 32'h0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) sig_in[i] = ~sig_in[i];
            end
            if ($urandom_range(0, 63) == 0) mode = 16'($urandom);
            clr = CH'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
